serial_subtractor_64bit: RTL and testbench
==========================================

Name: serial_subtractor_64bit

Overview:
- Multi-cycle bit-sliced subtractor. Computes diff = a - b - bin over WIDTH bits, processing one SLICE-bit slice per clock, least significant slice first.
- It is the inverse-direction companion of the team's registered 64-bit adder, aimed at area-constrained datapaths.
- Operands enter through a valid/ready input handshake. The result leaves through a valid/ready output handshake, together with borrow-out, zero and signed-overflow flags.

Parameters:
- WIDTH, 64, operand and result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per RUN cycle. NSLICE = WIDTH/SLICE (8 by default).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b and bin are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  downstream consumes the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned).
- zero  output  1  diff == 0.
- overflow  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
- Reset values:
  - state = IDLE, slice counter = 0, all operand and working registers = 0.
  - diff = 0, bout = 0, zero = 0, overflow = 0, out_valid = 0.
  - in_ready = 1, because it is decoded from state == IDLE.
- FSM, three states:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - latch a into a_sh, b into b_sh, bin into brw;
    - cnt <= 0;
    - go to RUN.
  - RUN: in_ready = 0. Each cycle:
    - combinational slice computes {brw_next, s} = a_sh[SLICE-1:0] - b_sh[SLICE-1:0] - brw;
    - a_sh and b_sh shift right by SLICE;
    - d_sh shifts right by SLICE with s inserted at the MSBs;
    - brw <= brw_next; cnt <= cnt + 1.
  - RUN completion: when cnt == NSLICE-1, the same edge loads the output registers and moves to DONE:
    - diff = final d_sh;
    - bout = brw_next;
    - zero = (final d_sh == 0);
    - overflow = (a63 ^ b63) & (a63 ^ d63), using the operand MSBs taken from the last slice;
    - out_valid <= 1.
  - DONE: out_valid = 1. diff and the flags hold stable. On out_ready: out_valid <= 0 and go to IDLE.
- Latency and throughput:
  - out_valid rises exactly NSLICE cycles after the accept edge (8 by default).
  - Throughput is at most one operation per NSLICE+2 cycles.
- Input handling:
  - in_valid outside IDLE is ignored; nothing is queued.
  - Operands are sampled only at the accept edge; later changes on a, b and bin have no effect.
- Output registers:
  - Change only at the RUN→DONE edge and on reset.
  - Hold their last result in IDLE and RUN.
  - Are meaningful only while out_valid = 1.
- Backpressure: out_ready low keeps the block in DONE indefinitely with outputs stable. out_ready while out_valid = 0 has no effect.
- Reset asserted mid-RUN or in DONE:
  - immediately returns to IDLE with all outputs at their reset values;
  - no partial result is ever presented.
- Arithmetic is unsigned modulo 2^WIDTH. overflow interprets a, b and diff as two's complement.

Decomposition:
- Package serial_arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default WIDTH and SLICE constants;
  - the counter-width function, clog2(NSLICE).
- Sub-module sub_slice: purely combinational SLICE-bit ripple full-subtractor, with inputs a, b, bin and outputs d, bout, instantiated once.
- Top level: FSM, shift registers, counter and output registers.

Test Plan:
- Reset: pulse rst low mid-RUN (cycle 4 after accept) -> out_valid stays 0, diff = 0, in_ready = 1 after release, no result emitted.
- Latency: a = 5, b = 3, bin = 0, out_ready = 1 -> diff = 2, bout = 0, zero = 0, overflow = 0; out_valid high exactly 8 cycles after the accept edge.
- Underflow and cross-slice borrow:
  - a = 0, b = 1 -> diff = 0xFFFF_FFFF_FFFF_FFFF, bout = 1, overflow = 0.
  - a = 0x0000_0001_0000_0000, b = 1 -> diff = 0x0000_0000_FFFF_FFFF, bout = 0.
- Signed overflow: a = 0x8000_0000_0000_0000, b = 1, bin = 0 -> diff = 0x7FFF_FFFF_FFFF_FFFF, overflow = 1, bout = 0.
- Zero and bin:
  - a = b = 0x1234_5678_9ABC_DEF0, bin = 0 -> diff = 0, zero = 1.
  - Same operands with bin = 1 -> diff = all ones, bout = 1, zero = 0.
- Backpressure: hold out_ready low 5 cycles in DONE while driving in_valid = 1 with new operands -> outputs stable, in_ready = 0, new operands not accepted. After out_ready, the next accept occurs in IDLE and produces the correct new result.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-sliced serial arithmetic units.
// Holds the sequencer state encoding, default sizes and counter sizing.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 8;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit ripple full-subtractor.
// Computes {bout, d} = a - b - bin.
module sub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic c;

  always_comb begin
    c = bin;
    d = '0;
    for (int i = 0; i < SLICE; i++) begin
      d[i] = a[i] ^ b[i] ^ c;
      c    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
    end
    bout = c;
  end

endmodule

// File: rtl/serial_subtractor_64bit.sv
// Multi-cycle bit-sliced subtractor: diff = a - b - bin, one slice per clock,
// LSB slice first, with valid/ready handshakes on both sides.
module serial_subtractor_64bit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE-1:0]       s;
  logic                   brw_next;
  logic [WIDTH+SLICE-1:0] d_cat;
  logic [WIDTH-1:0]       d_next;
  logic                   a_msb, b_msb;

  sub_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a   (a_sh_q[SLICE-1:0]),
    .b   (b_sh_q[SLICE-1:0]),
    .bin (brw_q),
    .d   (s),
    .bout(brw_next)
  );

  // New slice enters at the top; after NSLICE shifts d_sh is the full result.
  assign d_cat  = {s, d_sh_q};
  assign d_next = d_cat[WIDTH+SLICE-1:SLICE];
  assign a_msb  = a_sh_q[SLICE-1];
  assign b_msb  = b_sh_q[SLICE-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    d_sh_d      = d_sh_q;
    brw_d       = brw_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        a_sh_d = a_sh_q >> SLICE;
        b_sh_d = b_sh_q >> SLICE;
        d_sh_d = d_next;
        brw_d  = brw_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d      = d_next;
          bout_d      = brw_next;
          zero_d      = (d_next == '0);
          ovf_d       = (a_msb ^ b_msb) & (a_msb ^ s[SLICE-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      (state_q == DONE): begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      d_sh_q      <= '0;
      brw_q       <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      d_sh_q      <= d_sh_d;
      brw_q       <= brw_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_64bit.sv
// Scoreboard bench for serial_subtractor_64bit against a plain-arithmetic model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_serial_subtractor_64bit;

  localparam int NSL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] diff;
  logic        bout, zero, overflow;

  typedef struct {
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   pv = 1'b0;

  serial_subtractor_64bit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic c, input int acc);
    exp_t e;
    logic signed [65:0] sr;
    e.d  = x - y - 64'(c);
    e.bo = {1'b0, x} < ({1'b0, y} + 65'(c));
    e.z  = (e.d == 64'd0);
    sr   = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y})
         - $signed({65'd0, c});
    // Signed result fits 64 bits iff its top three bits agree.
    e.ov = !((sr[65:63] == 3'b000) || (sr[65:63] == 3'b111));
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: latency on rising out_valid, values on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
    end else begin
      if (out_valid && !pv) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid: got out_valid=1 want 0");
        end else begin
          chk("latency", 64'(cyc - sb[0].acc), 64'(NSL));
        end
      end
      pv = out_valid;
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", diff, e.d);
        chk("bout", 64'(bout), 64'(e.bo));
        chk("zero", 64'(zero), 64'(e.z));
        chk("overflow", 64'(overflow), 64'(e.ov));
      end
    end
  end

  task automatic issue(input logic [63:0] ia, input logic [63:0] ib,
                       input logic ibin, input bit push);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    a = ia;
    b = ib;
    bin = ibin;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back(model(ia, ib, ibin, cyc + 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    bin = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  logic [63:0] tv_a[8] = '{64'd5, 64'd0, 64'h0000_0001_0000_0000,
                           64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0,
                           64'h1234_5678_9ABC_DEF0, 64'h0,
                           64'h7FFF_FFFF_FFFF_FFFF};
  logic [63:0] tv_b[8] = '{64'd3, 64'd1, 64'd1, 64'd1,
                           64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
                           64'h8000_0000_0000_0000,
                           64'hFFFF_FFFF_FFFF_FFFF};
  logic        tv_c[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_diff", diff, 64'd0);
    chk("rst_flags", {61'd0, bout, zero, overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      issue(tv_a[i], tv_b[i], tv_c[i], 1'b1);
      drain();
    end

    // Reset mid-RUN: nothing may emerge afterwards.
    issue(64'd100, 64'd7, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_diff", diff, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Backpressure in DONE with ignored new operands.
    out_ready = 1'b0;
    issue(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_reached_done", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      if (sb.size() != 0) chk("bp_diff_stable", diff, sb[0].d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    issue(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0011, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 30; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      issue(ra, rb, 1'($urandom), 1'b1);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
